l2_prefetch_fill: RTL
=====================

# l2_prefetch_fill

Fill and coherency controller that drives the write port of the L2 prefetch buffer. After a CPU read miss it fetches DEPTH sequential longwords from the memory controller and writes them into the buffer. It forwards snooped CPU writes so buffered data stays coherent, and it can sweep-invalidate all 128 buffer entries. It sits between the CPU bus decode, the DRAM/ROM read port and the prefetch buffer's WRA/WRD/WR/WRM/CLR inputs.

## Interface
- DEPTH, 8: longwords fetched per miss, 1..128.
- CLK  in  1  system clock; everything is sampled on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Miss  in  1  one-cycle pulse: the CPU read at MissA missed the buffer.
- MissA  in  [27:2]  longword address of the miss.
- Flush  in  1  one-cycle pulse: invalidate all buffer entries.
- CPUWR  in  1  one-cycle pulse: CPU write snoop. Consecutive pulses are at least 2 cycles apart.
- CPUWRA  in  [27:2]  snoop write address.
- CPUWRD  in  [31:0]  snoop write data.
- CPUWRM  in  [3:0]  snoop byte-lane mask.
- MemReq  out  1  memory read request.
- MemA  out  [27:2]  memory read address.
- MemAck  in  1  one-cycle acknowledge; MemD is valid in this cycle.
- MemD  in  [31:0]  memory read data.
- WRA  out  [27:2]  buffer write address.
- WRD  out  [31:0]  buffer write data.
- WR  out  1  buffer write strobe, one cycle per write.
- WRM  out  [3:0]  buffer byte mask.
- CLR  out  1  buffer write clears the valid bit.
- Busy  out  1  state is not IDLE.

## Operation
- **States:** IDLE, FETCH, WRITE, FLUSH.
- **IDLE**
  - Flush → FLUSH with idx=0. Flush wins over a simultaneous Miss; that Miss is dropped.
  - Miss → FETCH with MemA=MissA, cnt=DEPTH-1, stale=0.
- **FETCH**
  - MemReq=1 and MemA is held stable until MemAck.
  - On MemAck: capture MemD into the data register, set MemReq=0 (registered), go to WRITE.
  - There is no way to cancel a request once issued.
- **WRITE**
  - Issue one buffer write: WRA=MemA, WRD=captured data, WRM=4'b1111, CLR=stale.
  - Afterwards:
    - If a pending Miss is held, restart FETCH at the pending address.
    - Else if a pending Flush is held, go to FLUSH.
    - Else if cnt=0, go to IDLE.
    - Else MemA=MemA+1 (modulo 2^26), cnt−1, stale=0, go to FETCH.
- **Miss or Flush during FETCH/WRITE**
  - Latched into a single pending slot; a later event overwrites an earlier one, and Flush overwrites Miss.
  - Serviced only after the current word's WRITE completes.
- **FLUSH**
  - Each granted cycle: WRA={19'b0, idx[6:0]}, WRM=4'b1111, CLR=1, WRD=0, then idx+1.
  - After idx=127, go to IDLE.
  - Miss arriving during FLUSH is latched as pending and serviced on exit.
- **Snoop forwarding**
  - CPUWR is registered and, in the next cycle, issued unconditionally as WRA/WRD/WRM=CPUWR*, CLR=0.
  - The buffer itself decides whether a partial-mask write hits.
  - Snoop has absolute priority on the write port. A WRITE or FLUSH write colliding with it is held one cycle, with state and counters frozen.
- **Stale rule**
  - If a snoop address equals MemA while in FETCH, or in WRITE before the write issues, set stale=1.
  - The fetched word is then written with CLR=1, invalidating that index.

## Timing
- **Reset values:** MemReq=0, MemA=0, WR=0, WRM=0, WRA=0, WRD=0, CLR=0, Busy=0; state=IDLE; pending cleared.
- **Reset mid-operation:** everything is abandoned immediately. The memory controller tolerates MemReq dropping without an ack.
- All outputs are registered.
- **Miss latency:** Miss at cycle t → MemReq=1 at t+1.
- **Ack to write:** MemAck at t → MemReq=0 and WR=1 at t+1 (unless a snoop collides); next MemReq=1 at t+2.
- **Throughput:** at best one word per 2 cycles plus memory latency.
- **Snoop latency:** CPUWR at t → WR=1 at t+1.
- **Flush duration:** 128 write cycles plus one per colliding snoop.
- Busy=1 from the cycle after the Miss/Flush pulse until the return to IDLE.
- **Address wrap:** 28'hFFFFFFC → 0.

## Test plan
- Miss MissA=26'h0000100, DEPTH=8, MemAck 3 cycles after each request → MemA 100..107, eight WR pulses, WRM=F, CLR=0, data matches MemD; Busy drops after the last WR.
- CPUWR to CPUWRA=MemA during FETCH → snoop WR with CPUWRM first; the fetched word is then written with CLR=1; the following word has CLR=0.
- CPUWR arriving the same cycle a fill write is due → snoop WR at t+1, fill WR at t+2 with the original data/address.
- Miss to 26'h0000200 while fetching word 3 of 8 at 26'h100 → word 3 written, then MemA=200; no writes for 104–107.
- Flush in IDLE with a Miss one cycle later → WRA indices 0..127 with CLR=1, then fetch starts from the latched Miss.
- Miss at 26'h3FFFFFE, DEPTH=4 → MemA 3FFFFFE, 3FFFFFF, 0000000, 0000001; RST asserted mid-FETCH → MemReq=0 and Busy=0 immediately.

Source files
------------

// File: rtl/l2_prefetch_fill_if.sv
// l2_prefetch_fill_if
// Bundles the signals between the L2 prefetch fill controller and its
// surroundings: CPU miss/flush/snoop inputs, the memory read port and the
// prefetch buffer write port.
//   master : the fill controller (drives memory request and buffer writes)
//   slave  : the environment (CPU decode, memory controller, buffer)
interface l2_prefetch_fill_if;
   // CPU side
   logic        miss;
   logic [27:2] miss_a;
   logic        flush;
   logic        cpu_wr;
   logic [27:2] cpu_wr_a;
   logic [31:0] cpu_wr_d;
   logic [3:0]  cpu_wr_m;
   // memory read port
   logic        mem_req;
   logic [27:2] mem_a;
   logic        mem_ack;
   logic [31:0] mem_d;
   // prefetch buffer write port
   logic [27:2] wr_a;
   logic [31:0] wr_d;
   logic        wr;
   logic [3:0]  wr_m;
   logic        clr;
   logic        busy;

   modport master (
      input  miss, miss_a, flush, cpu_wr, cpu_wr_a, cpu_wr_d, cpu_wr_m,
      input  mem_ack, mem_d,
      output mem_req, mem_a,
      output wr_a, wr_d, wr, wr_m, clr, busy
   );

   modport slave (
      output miss, miss_a, flush, cpu_wr, cpu_wr_a, cpu_wr_d, cpu_wr_m,
      output mem_ack, mem_d,
      input  mem_req, mem_a,
      input  wr_a, wr_d, wr, wr_m, clr, busy
   );
endinterface

// File: rtl/l2_prefetch_fill.sv
// l2_prefetch_fill
// Fill and coherency controller for the L2 prefetch buffer write port.
// A read miss fetches DEPTH sequential longwords from memory and writes them
// into the buffer; snooped CPU writes are forwarded with top priority so the
// buffer stays coherent; a flush sweeps all 128 entries invalid.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : l2_prefetch_fill_if.master (miss/flush/snoop in, memory port,
//            buffer write port, busy); every output is registered.
module l2_prefetch_fill #(
   parameter int DEPTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   l2_prefetch_fill_if.master bus
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_WRITE = 2'd2, ST_FLUSH = 2'd3} state_t;
   typedef enum logic [1:0] {PD_NONE = 2'd0, PD_MISS = 2'd1, PD_FLUSH = 2'd2} pend_t;

   localparam logic [6:0] C_CNT_INIT = 7'(DEPTH - 1);
   localparam logic [6:0] C_IDX_LAST = 7'd127;

   state_t      r_state,   w_state;
   logic        r_mem_req, w_mem_req;
   logic [27:2] r_mem_a,   w_mem_a;
   logic [6:0]  r_cnt,     w_cnt;
   logic        r_stale,   w_stale;
   logic [31:0] r_data,    w_data;
   logic        r_issued,  w_issued;   // current word's buffer write already went out
   logic [6:0]  r_idx,     w_idx;
   pend_t       r_pend,    w_pend;
   logic [27:2] r_pend_a,  w_pend_a;
   logic        r_wr,      w_wr;
   logic [27:2] r_wr_a,    w_wr_a;
   logic [31:0] r_wr_d,    w_wr_d;
   logic [3:0]  r_wr_m,    w_wr_m;
   logic        r_clr,     w_clr;
   logic        r_busy,    w_busy;

   pend_t       w_pend_eff;
   logic [27:2] w_pend_a_eff;
   logic        w_port_free;
   logic        w_snoop_hit;

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_mem_req <= 1'b0;
         r_mem_a   <= 26'd0;
         r_cnt     <= 7'd0;
         r_stale   <= 1'b0;
         r_data    <= 32'd0;
         r_issued  <= 1'b0;
         r_idx     <= 7'd0;
         r_pend    <= PD_NONE;
         r_pend_a  <= 26'd0;
         r_wr      <= 1'b0;
         r_wr_a    <= 26'd0;
         r_wr_d    <= 32'd0;
         r_wr_m    <= 4'd0;
         r_clr     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_mem_req <= w_mem_req;
         r_mem_a   <= w_mem_a;
         r_cnt     <= w_cnt;
         r_stale   <= w_stale;
         r_data    <= w_data;
         r_issued  <= w_issued;
         r_idx     <= w_idx;
         r_pend    <= w_pend;
         r_pend_a  <= w_pend_a;
         r_wr      <= w_wr;
         r_wr_a    <= w_wr_a;
         r_wr_d    <= w_wr_d;
         r_wr_m    <= w_wr_m;
         r_clr     <= w_clr;
         r_busy    <= w_busy;
      end
   end

   // Next-state, pending-event and write-port arbitration logic.
   always_comb begin
      w_state   = r_state;
      w_mem_req = r_mem_req;
      w_mem_a   = r_mem_a;
      w_cnt     = r_cnt;
      w_stale   = r_stale;
      w_data    = r_data;
      w_issued  = r_issued;
      w_idx     = r_idx;
      w_wr      = 1'b0;
      w_wr_a    = r_wr_a;
      w_wr_d    = r_wr_d;
      w_wr_m    = r_wr_m;
      w_clr     = r_clr;

      // Pending slot as it stands including this cycle's events: newest wins,
      // a simultaneous flush beats a miss, and a flush while flushing is moot.
      w_pend_eff   = r_pend;
      w_pend_a_eff = r_pend_a;
      if (bus.flush && (r_state != ST_FLUSH)) begin
         w_pend_eff = PD_FLUSH;
      end else if (bus.miss) begin
         w_pend_eff   = PD_MISS;
         w_pend_a_eff = bus.miss_a;
      end else begin
         w_pend_eff = r_pend;
      end
      w_pend   = w_pend_eff;
      w_pend_a = w_pend_a_eff;

      w_snoop_hit = bus.cpu_wr && (bus.cpu_wr_a == r_mem_a);
      w_port_free = !bus.cpu_wr;

      // A snoop owns the write port; fill and flush writes wait for a free cycle.
      if (bus.cpu_wr) begin
         w_wr   = 1'b1;
         w_wr_a = bus.cpu_wr_a;
         w_wr_d = bus.cpu_wr_d;
         w_wr_m = bus.cpu_wr_m;
         w_clr  = 1'b0;
      end else begin
         w_wr = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            w_pend = PD_NONE;
            if (bus.flush) begin
               w_state = ST_FLUSH;
               w_idx   = 7'd0;
            end else if (bus.miss) begin
               w_state   = ST_FETCH;
               w_mem_a   = bus.miss_a;
               w_cnt     = C_CNT_INIT;
               w_stale   = 1'b0;
               w_mem_req = 1'b1;
            end else begin
               w_state = ST_IDLE;
            end
         end
         ST_FETCH: begin
            w_stale = r_stale | w_snoop_hit;
            if (bus.mem_ack) begin
               w_data    = bus.mem_d;
               w_mem_req = 1'b0;
               w_state   = ST_WRITE;
               // Write straight from the ack cycle unless a snoop takes the port.
               if (w_port_free) begin
                  w_wr     = 1'b1;
                  w_wr_a   = r_mem_a;
                  w_wr_d   = bus.mem_d;
                  w_wr_m   = 4'b1111;
                  w_clr    = w_stale;
                  w_issued = 1'b1;
               end else begin
                  w_issued = 1'b0;
               end
            end else begin
               w_state = ST_FETCH;
            end
         end
         ST_WRITE: begin
            if (!r_issued) begin
               w_stale = r_stale | w_snoop_hit;
               if (w_port_free) begin
                  w_wr     = 1'b1;
                  w_wr_a   = r_mem_a;
                  w_wr_d   = r_data;
                  w_wr_m   = 4'b1111;
                  w_clr    = w_stale;
                  w_issued = 1'b1;
               end else begin
                  w_issued = 1'b0;
               end
            end else if (w_pend_eff == PD_MISS) begin
               w_state   = ST_FETCH;
               w_mem_a   = w_pend_a_eff;
               w_cnt     = C_CNT_INIT;
               w_stale   = 1'b0;
               w_mem_req = 1'b1;
               w_pend    = PD_NONE;
            end else if (w_pend_eff == PD_FLUSH) begin
               w_state = ST_FLUSH;
               w_idx   = 7'd0;
               w_pend  = PD_NONE;
            end else if (r_cnt == 7'd0) begin
               w_state = ST_IDLE;
               w_pend  = PD_NONE;
            end else begin
               w_state   = ST_FETCH;
               w_mem_a   = r_mem_a + 26'd1;
               w_cnt     = r_cnt - 7'd1;
               w_stale   = 1'b0;
               w_mem_req = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (w_port_free) begin
               w_wr   = 1'b1;
               w_wr_a = {19'd0, r_idx};
               w_wr_d = 32'd0;
               w_wr_m = 4'b1111;
               w_clr  = 1'b1;
               w_idx  = r_idx + 7'd1;
               if (r_idx == C_IDX_LAST) begin
                  w_pend = PD_NONE;
                  if (w_pend_eff == PD_MISS) begin
                     w_state   = ST_FETCH;
                     w_mem_a   = w_pend_a_eff;
                     w_cnt     = C_CNT_INIT;
                     w_stale   = 1'b0;
                     w_mem_req = 1'b1;
                  end else begin
                     w_state = ST_IDLE;
                  end
               end else begin
                  w_state = ST_FLUSH;
               end
            end else begin
               w_state = ST_FLUSH;
            end
         end
         default: begin
            w_state   = ST_IDLE;
            w_mem_req = 1'b0;
            w_pend    = PD_NONE;
         end
      endcase

      w_busy = (w_state != ST_IDLE);
   end

   assign bus.mem_req = r_mem_req;
   assign bus.mem_a   = r_mem_a;
   assign bus.wr      = r_wr;
   assign bus.wr_a    = r_wr_a;
   assign bus.wr_d    = r_wr_d;
   assign bus.wr_m    = r_wr_m;
   assign bus.clr     = r_clr;
   assign bus.busy    = r_busy;
endmodule
